// File: rtl/dc_pkg.sv
// -----------------------------------------------------------------------------
// dc_pkg
// Shared types and defaults for the read/write request arbiter slice.
//   - ID_W_DEF / ADDR_W_DEF : default AXI ID and address widths
//   - arb_state_e           : output slot state (EMPTY / FULL)
//   - grant_e               : which channel was granted (GRANT_RD / GRANT_WR)
//   - GNT_RD_BIT/GNT_WR_BIT : bit positions inside the one-hot grant vector
// -----------------------------------------------------------------------------
package dc_pkg;

    localparam int ID_W_DEF   = 16;
    localparam int ADDR_W_DEF = 64;

    localparam int GNT_RD_BIT = 0;
    localparam int GNT_WR_BIT = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

    // Collapse a one-hot {wr, rd} grant into the channel enum.
    // Only meaningful when exactly one bit is set.
    function automatic grant_e onehot_to_grant(input logic [1:0] gnt);
        return gnt[GNT_WR_BIT] ? GRANT_WR : GRANT_RD;
    endfunction

endpackage : dc_pkg

// File: rtl/dc_rr_arb2.sv
// -----------------------------------------------------------------------------
// dc_rr_arb2
// Two-requester round-robin arbiter, purely combinational.
//   i_req[0]      : read request
//   i_req[1]      : write request
//   i_last_grant  : channel granted most recently
//   o_grant[1:0]  : one-hot grant (bit 0 = read, bit 1 = write), zero if idle
// A lone requester always wins; on a tie the channel that did not win last
// time is chosen.
// -----------------------------------------------------------------------------
module dc_rr_arb2
    import dc_pkg::*;
(
    input  logic [1:0] i_req,
    input  grant_e     i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant[GNT_RD_BIT] = 1'b1;
            2'b10:   o_grant[GNT_WR_BIT] = 1'b1;
            2'b11: begin
                if (i_last_grant == GRANT_WR) begin
                    o_grant[GNT_RD_BIT] = 1'b1;
                end else begin
                    o_grant[GNT_WR_BIT] = 1'b1;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule : dc_rr_arb2

// File: rtl/dc_req_arbiter.sv
// -----------------------------------------------------------------------------
// dc_req_arbiter
// Arbitrates the AXI AR and AW address channels into a single registered
// request slot feeding the index extractor.
//
// Ports
//   clk, rst_n                      : clock, async active-low reset
//   arid_i/araddr_i/arvalid_i       : read-address request
//   arready_o                       : read request accepted this cycle
//   awid_i/awaddr_i/awvalid_i       : write-address request
//   awready_o                       : write request accepted this cycle
//   req_id_o/req_addr_o/req_wr_o    : granted request payload (wr=1 -> write)
//   req_valid_o / req_ready_i       : handshake toward the index extractor
//   tag_fifo_afull_i                : blocks acceptance of new requests
//   rd_grant_cnt_o/wr_grant_cnt_o   : saturating grant counters, present only
//                                     when DC_ARB_PERF_CNT_EN is defined
//
// State table
//   state | meaning
//   EMPTY | no request held, req_valid_o=0
//   FULL  | request held in the slot, req_valid_o=1
// -----------------------------------------------------------------------------
module dc_req_arbiter
    import dc_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,

    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,

    output logic [ID_W-1:0]   req_id_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_wr_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,

    input  logic              tag_fifo_afull_i
`ifdef DC_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       rd_grant_cnt_o,
    output logic [31:0]       wr_grant_cnt_o
`endif
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    grant_e            r_last_grant;
    grant_e            w_last_grant_nxt;

    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;

    logic              w_accept;
    logic [1:0]        w_grant;
    logic              w_rd_hs;
    logic              w_wr_hs;
    logic              w_any_hs;

    dc_rr_arb2 u_rr_arb2 (
        .i_req        ({awvalid_i, arvalid_i}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // rst_n is folded in so both readies are held low for the whole time
    // reset is asserted, not just after the first clock edge.
    assign w_accept = rst_n && !tag_fifo_afull_i &&
                      ((r_state == EMPTY) || req_ready_i);

    assign w_rd_hs  = w_accept && w_grant[GNT_RD_BIT];
    assign w_wr_hs  = w_accept && w_grant[GNT_WR_BIT];
    assign w_any_hs = w_rd_hs || w_wr_hs;

    assign arready_o = w_rd_hs;
    assign awready_o = w_wr_hs;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;

        if (w_any_hs) begin
            w_last_grant_nxt = onehot_to_grant(w_grant);
        end

        unique case (r_state)
            EMPTY: begin
                if (w_any_hs) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                // A new grant while draining keeps the slot full so
                // back-to-back requests flow at one per cycle.
                if (req_ready_i && !w_any_hs) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_last_grant <= GRANT_WR;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Payload only moves on a handshake; while FULL and stalled it is
    // untouched, which keeps the outputs stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id   <= '0;
            r_addr <= '0;
            r_wr   <= 1'b0;
        end else if (w_rd_hs) begin
            r_id   <= arid_i;
            r_addr <= araddr_i;
            r_wr   <= 1'b0;
        end else if (w_wr_hs) begin
            r_id   <= awid_i;
            r_addr <= awaddr_i;
            r_wr   <= 1'b1;
        end
    end

    assign req_id_o    = r_id;
    assign req_addr_o  = r_addr;
    assign req_wr_o    = r_wr;
    assign req_valid_o = (r_state == FULL);

`ifdef DC_ARB_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_hs && (r_rd_cnt != 32'hFFFF_FFFF)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_hs && (r_wr_cnt != 32'hFFFF_FFFF)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_grant_cnt_o = r_rd_cnt;
    assign wr_grant_cnt_o = r_wr_cnt;
`endif

endmodule : dc_req_arbiter

// File: tb/tb_dc_req_arbiter.sv
module tb_dc_req_arbiter;

    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [ID_W-1:0]   req_id_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_wr_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic              tag_fifo_afull_i;
`ifdef DC_ARB_PERF_CNT_EN
    logic [31:0]       rd_grant_cnt_o;
    logic [31:0]       wr_grant_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    dc_req_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arid_i           (arid_i),
        .araddr_i         (araddr_i),
        .arvalid_i        (arvalid_i),
        .arready_o        (arready_o),
        .awid_i           (awid_i),
        .awaddr_i         (awaddr_i),
        .awvalid_i        (awvalid_i),
        .awready_o        (awready_o),
        .req_id_o         (req_id_o),
        .req_addr_o       (req_addr_o),
        .req_wr_o         (req_wr_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .tag_fifo_afull_i (tag_fifo_afull_i)
`ifdef DC_ARB_PERF_CNT_EN
        ,
        .rd_grant_cnt_o   (rd_grant_cnt_o),
        .wr_grant_cnt_o   (wr_grant_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              arv;
        logic [ADDR_W-1:0] araddr;
        logic [ID_W-1:0]   arid;
        logic              awv;
        logic [ADDR_W-1:0] awaddr;
        logic [ID_W-1:0]   awid;
        logic              rdy;
        logic              afull;
        // expected same cycle
        logic              e_arr;
        logic              e_awr;
        // expected after the edge
        logic              e_vld;
        logic [ADDR_W-1:0] e_addr;
        logic [ID_W-1:0]   e_id;
        logic              e_wr;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic arv, input logic [ADDR_W-1:0] araddr, input logic [ID_W-1:0] arid,
                         input logic awv, input logic [ADDR_W-1:0] awaddr, input logic [ID_W-1:0] awid,
                         input logic rdy, input logic afull);
        arvalid_i = arv; araddr_i = araddr; arid_i = arid;
        awvalid_i = awv; awaddr_i = awaddr; awid_i = awid;
        req_ready_i = rdy; tag_fifo_afull_i = afull;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        drive(0, '0, '0, 0, '0, '0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Sample comb readies mid-cycle, then move to posedge+1.
    task automatic cyc_rdy(input string name, input logic e_ar, input logic e_aw);
        #3;
        chk({name, ".arready"}, arready_o, e_ar);
        chk({name, ".awready"}, awready_o, e_aw);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            arv araddr                  arid     awv awaddr                  awid     rdy af  arr awr vld addr                    id       wr
        vec[0]  = '{1, 64'h64,                  16'h0,   0, 64'h0,                   16'h0,   1, 0,  1, 0, 1, 64'h64,                  16'h0,   0};
        vec[1]  = '{0, 64'h0,                   16'h0,   0, 64'h0,                   16'h0,   1, 0,  0, 0, 0, 64'h64,                  16'h0,   0};
        vec[2]  = '{0, 64'h0,                   16'h0,   1, 64'hC8,                  16'h5,   0, 0,  0, 1, 1, 64'hC8,                  16'h5,   1};
        vec[3]  = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   0, 0,  0, 0, 1, 64'hC8,                  16'h5,   1};
        vec[4]  = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   1, 0,  1, 0, 1, 64'h80,                  16'h3,   0};
        vec[5]  = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   1, 0,  0, 1, 1, 64'hC8,                  16'h5,   1};
        vec[6]  = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   1, 1,  0, 0, 0, 64'hC8,                  16'h5,   1};
        vec[7]  = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   0, 0,  1, 0, 1, 64'h80,                  16'h3,   0};
        vec[8]  = '{1, 64'hFEDC_BA98_7654_3210, 16'hFFFF,0, 64'h0,                   16'h0,   1, 0,  1, 0, 1, 64'hFEDC_BA98_7654_3210, 16'hFFFF,0};
        vec[9]  = '{0, 64'h0,                   16'h0,   1, 64'h8000_0000_0000_0001, 16'h8001,1, 0,  0, 1, 1, 64'h8000_0000_0000_0001, 16'h8001,1};
        vec[10] = '{1, 64'h80,                  16'h3,   1, 64'hC8,                  16'h5,   1, 0,  1, 0, 1, 64'h80,                  16'h3,   0};

        rst_n = 1'b0;
        drive(0, '0, '0, 0, '0, '0, 0, 0);
        do_reset();

        chk("reset.valid", req_valid_o, 1'b0);
        chk("reset.addr",  req_addr_o,  64'h0);
        chk("reset.id",    req_id_o,    16'h0);
        chk("reset.wr",    req_wr_o,    1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].arv, vec[i].araddr, vec[i].arid, vec[i].awv, vec[i].awaddr,
                  vec[i].awid, vec[i].rdy, vec[i].afull);
            cyc_rdy($sformatf("vec%0d", i), vec[i].e_arr, vec[i].e_awr);
            chk($sformatf("vec%0d.valid", i), req_valid_o, vec[i].e_vld);
            chk($sformatf("vec%0d.addr", i),  req_addr_o,  vec[i].e_addr);
            chk($sformatf("vec%0d.id", i),    req_id_o,    vec[i].e_id);
            chk($sformatf("vec%0d.wr", i),    req_wr_o,    vec[i].e_wr);
        end

        // Alternating tie grants starting with read
        do_reset();
        drive(1, 64'h80, 16'h1, 1, 64'hC8, 16'h2, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc_rdy($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
            chk($sformatf("rr%0d.valid", k), req_valid_o, 1'b1);
            chk($sformatf("rr%0d.wr", k),    req_wr_o,    (k % 2) == 1);
            chk($sformatf("rr%0d.addr", k),  req_addr_o,  ((k % 2) == 1) ? 64'hC8 : 64'h80);
        end

        // Back-pressure: held request stays put, AW waits
        do_reset();
        drive(0, '0, '0, 1, 64'h1C0, 16'h9, 0, 0);
        cyc_rdy("bp.load", 0, 1);
        drive(0, '0, '0, 1, 64'h2C0, 16'hA, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc_rdy($sformatf("bp%0d", k), 0, 0);
            chk($sformatf("bp%0d.valid", k), req_valid_o, 1'b1);
            chk($sformatf("bp%0d.addr", k),  req_addr_o,  64'h1C0);
        end
        tag_fifo_afull_i = 1'b1;
        cyc_rdy("bp.afull", 0, 0);
        chk("bp.afull.valid", req_valid_o, 1'b1);
        chk("bp.afull.addr",  req_addr_o,  64'h1C0);
        tag_fifo_afull_i = 1'b0;
        req_ready_i = 1'b1;
        cyc_rdy("bp.release", 0, 1);
        chk("bp.release.addr", req_addr_o, 64'h2C0);
        chk("bp.release.id",   req_id_o,   16'hA);

        // Almost-full blocks acceptance from EMPTY; read wins once it drops
        do_reset();
        drive(1, 64'h80, 16'h1, 1, 64'hC8, 16'h2, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc_rdy($sformatf("af%0d", k), 0, 0);
            chk($sformatf("af%0d.valid", k), req_valid_o, 1'b0);
        end
        tag_fifo_afull_i = 1'b0;
        cyc_rdy("af.drop", 1, 0);
        chk("af.drop.valid", req_valid_o, 1'b1);
        chk("af.drop.wr",    req_wr_o,    1'b0);

        // Async reset while FULL
        do_reset();
        drive(0, '0, '0, 1, 64'h40, 16'h3, 1, 0);
        cyc_rdy("ar.pre", 0, 1);                 // last grant now WR
        drive(1, 64'hA0, 16'h7, 0, '0, '0, 0, 0);
        cyc_rdy("ar.load", 0, 0);                // FULL, stalled, no accept
        chk("ar.load.id", req_id_o, 16'h3);
        drive(1, 64'hA0, 16'h7, 0, '0, '0, 1, 0);
        cyc_rdy("ar.load7", 1, 0);
        chk("ar.load7.id",    req_id_o,    16'h7);
        chk("ar.load7.valid", req_valid_o, 1'b1);
        drive(1, 64'hA0, 16'h7, 1, 64'hB0, 16'h8, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.rst.valid",   req_valid_o, 1'b0);
        chk("ar.rst.id",      req_id_o,    16'h0);
        chk("ar.rst.arready", arready_o,   1'b0);
        chk("ar.rst.awready", awready_o,   1'b0);
        @(posedge clk);
        #1;
        chk("ar.rst.hold.arready", arready_o, 1'b0);
        chk("ar.rst.hold.awready", awready_o, 1'b0);
        rst_n = 1'b1;
        cyc_rdy("ar.after", 1, 0);
        chk("ar.after.wr", req_wr_o, 1'b0);

`ifdef DC_ARB_PERF_CNT_EN
        do_reset();
        chk("perf.rst.rd", rd_grant_cnt_o, 32'd0);
        chk("perf.rst.wr", wr_grant_cnt_o, 32'd0);
        drive(1, 64'h10, 16'h1, 0, '0, '0, 1, 0);
        repeat (10) begin @(posedge clk); #1; end
        drive(0, '0, '0, 1, 64'h20, 16'h2, 1, 0);
        repeat (6) begin @(posedge clk); #1; end
        drive(0, '0, '0, 0, '0, '0, 1, 0);
        @(posedge clk); #1;
        chk("perf.rd", rd_grant_cnt_o, 32'd10);
        chk("perf.wr", wr_grant_cnt_o, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dc_req_arbiter
